// File: rtl/bip_control.sv
`default_nettype none
// ============================================================================
//  Module   : bip_control
//  Purpose  : Instruction sequencer for the accumulator processor. Runs a
//             two-cycle FETCH/EXEC loop over a synchronous-read program
//             memory and drives the accumulator datapath and data-memory
//             control lines from the decoded opcode.
//  Options  : BIP_CYCLE_COUNTER_EN - when defined, cycle_count counts clocks
//             spent in FETCH/EXEC (saturating); otherwise it is tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module bip_control #(
  parameter int PC_WIDTH    = 11,
  parameter int INSTR_WIDTH = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    pc,
  output logic [PC_WIDTH-1:0]    operand,
  output logic [1:0]             sel_a,
  output logic                   sel_b,
  output logic                   wr_acc,
  output logic                   op,
  output logic                   wr_ram,
  output logic                   rd_ram,
  output logic                   halted,
  output logic [CNT_WIDTH-1:0]   cycle_count
);

  localparam int OPC_WIDTH = 5;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [OPC_WIDTH-1:0] OPC_HLT  = 5'b00000;
  localparam logic [OPC_WIDTH-1:0] OPC_STO  = 5'b00001;
  localparam logic [OPC_WIDTH-1:0] OPC_LD   = 5'b00010;
  localparam logic [OPC_WIDTH-1:0] OPC_LDI  = 5'b00011;
  localparam logic [OPC_WIDTH-1:0] OPC_ADD  = 5'b00100;
  localparam logic [OPC_WIDTH-1:0] OPC_ADDI = 5'b00101;
  localparam logic [OPC_WIDTH-1:0] OPC_SUB  = 5'b00110;
  localparam logic [OPC_WIDTH-1:0] OPC_SUBI = 5'b00111;

  logic [1:0]           state_q, state_d;
  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic                 halted_q;
  logic [OPC_WIDTH-1:0] opcode;
  logic                 in_exec;

  assign opcode  = instr[INSTR_WIDTH-1 -: OPC_WIDTH];
  assign in_exec = (state_q == S_EXEC);

  // Next-state and program-counter update for the FETCH/EXEC loop
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_FETCH;
      S_FETCH: state_d = S_EXEC;
      S_EXEC: begin
        if (opcode == OPC_HLT) begin
          state_d = S_HALT;
        end else begin
          state_d = S_FETCH;
          pc_d    = pc_q + PC_WIDTH'(1);
        end
      end
      default: state_d = S_HALT;
    endcase
  end

  // State, PC and halt flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= (state_d == S_HALT);
    end
  end

  // Opcode decode; strobes are live only in EXEC and are killed by reset
  // so that a reset landing mid-instruction never commits a write
  always_comb begin
    sel_a  = 2'b00;
    sel_b  = 1'b0;
    op     = 1'b0;
    wr_acc = 1'b0;
    wr_ram = 1'b0;
    rd_ram = 1'b0;
    if (in_exec && !reset) begin
      case (opcode)
        OPC_STO: wr_ram = 1'b1;
        OPC_LD: begin
          rd_ram = 1'b1;
          wr_acc = 1'b1;
        end
        OPC_LDI: begin
          sel_a  = 2'b01;
          wr_acc = 1'b1;
        end
        OPC_ADD, OPC_SUB: begin
          rd_ram = 1'b1;
          sel_a  = 2'b10;
          op     = (opcode == OPC_SUB);
          wr_acc = 1'b1;
        end
        OPC_ADDI, OPC_SUBI: begin
          sel_a  = 2'b10;
          sel_b  = 1'b1;
          op     = (opcode == OPC_SUBI);
          wr_acc = 1'b1;
        end
        default: ;  // HLT and the NOP range drive no strobes
      endcase
    end
  end

  assign operand = in_exec ? instr[PC_WIDTH-1:0] : '0;
  assign pc      = pc_q;
  assign halted  = halted_q;

`ifdef BIP_CYCLE_COUNTER_EN
  logic [CNT_WIDTH-1:0] cnt_q;

  // Saturating count of clocks spent executing (FETCH or EXEC)
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if ((state_q == S_FETCH || state_q == S_EXEC) && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign cycle_count = cnt_q;
`else
  assign cycle_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bip_control.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bip_control
//  Purpose  : Directed self-checking bench for bip_control with a
//             synchronous-read program memory model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bip_control;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] instr;
  logic [10:0] pc;
  logic [10:0] operand;
  logic [1:0]  sel_a;
  logic        sel_b;
  logic        wr_acc;
  logic        op;
  logic        wr_ram;
  logic        rd_ram;
  logic        halted;
  logic [31:0] cycle_count;

  logic [15:0] mem [0:2047];
  logic [29:0] obs;

  int errors = 0;
  int checks = 0;

  bip_control #(.PC_WIDTH(11), .INSTR_WIDTH(16), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .instr(instr), .pc(pc),
    .operand(operand), .sel_a(sel_a), .sel_b(sel_b), .wr_acc(wr_acc),
    .op(op), .wr_ram(wr_ram), .rd_ram(rd_ram), .halted(halted),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // Synchronous-read program memory
  always @(posedge clk) instr <= mem[pc];

  assign obs = {pc, operand, sel_a, sel_b, op, wr_acc, wr_ram, rd_ram, halted};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_mem(input logic [15:0] v);
    for (int i = 0; i < 2048; i++) mem[i] = v;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (3) step();
    reset = 1'b0;
  endtask

  // Leaves the bench in cycle 1 (FETCH of address 0)
  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (obs !== 30'd0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: got %h expected %h", c, obs, 30'd0);
      end
      checks++;
      if (cycle_count !== 32'd0) begin
        errors++;
        $display("FAIL reset_count cycle %0d: got %0d expected 0", c, cycle_count);
      end
    end
  endtask

  // LDI 5; ADDI 3; STO 7; HLT
  task automatic test_ldi_addi_sto();
    logic [29:0] exp_t [1:9];
    logic [31:0] exp_cnt;
    exp_t[1] = {11'd0, 11'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_t[2] = {11'd0, 11'd5, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_t[3] = {11'd1, 11'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_t[4] = {11'd1, 11'd3, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_t[5] = {11'd2, 11'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_t[6] = {11'd2, 11'd7, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    exp_t[7] = {11'd3, 11'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_t[8] = {11'd3, 11'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_t[9] = {11'd3, 11'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`ifdef BIP_CYCLE_COUNTER_EN
    exp_cnt = 32'd8;
`else
    exp_cnt = 32'd0;
`endif
    fill_mem(16'h0000);
    mem[0] = 16'h1805;  // LDI 5
    mem[1] = 16'h2803;  // ADDI 3
    mem[2] = 16'h0807;  // STO 7
    mem[3] = 16'h0000;  // HLT
    do_reset();
    kick();
    for (int c = 1; c <= 9; c++) begin
      checks++;
      if (obs !== exp_t[c]) begin
        errors++;
        $display("FAIL prog1 cycle %0d: got %h expected %h", c, obs, exp_t[c]);
      end
      if (c < 9) step();
    end
    checks++;
    if (cycle_count !== exp_cnt) begin
      errors++;
      $display("FAIL prog1_count: got %0d expected %0d", cycle_count, exp_cnt);
    end
    // start while halted must be ignored
    kick();
    repeat (3) step();
    checks++;
    if (obs !== exp_t[9]) begin
      errors++;
      $display("FAIL halt_sticky: got %h expected %h", obs, exp_t[9]);
    end
    checks++;
    if (cycle_count !== exp_cnt) begin
      errors++;
      $display("FAIL halt_count_hold: got %0d expected %0d", cycle_count, exp_cnt);
    end
  endtask

  // LD 3; SUB 4; HLT
  task automatic test_ld_sub();
    logic [29:0] exp_t [1:8];
    exp_t[1] = {11'd0, 11'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_t[2] = {11'd0, 11'd3, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exp_t[3] = {11'd1, 11'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_t[4] = {11'd1, 11'd4, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    exp_t[5] = {11'd2, 11'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_t[6] = {11'd2, 11'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_t[7] = {11'd2, 11'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_t[8] = {11'd2, 11'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    fill_mem(16'h0000);
    mem[0] = 16'h1003;  // LD 3
    mem[1] = 16'h3004;  // SUB 4
    do_reset();
    kick();
    for (int c = 1; c <= 8; c++) begin
      checks++;
      if (obs !== exp_t[c]) begin
        errors++;
        $display("FAIL ld_sub cycle %0d: got %h expected %h", c, obs, exp_t[c]);
      end
      if (c < 8) step();
    end
  endtask

  // Opcode 11111 (NOP) with a non-zero operand field, then HLT
  task automatic test_nop();
    logic [29:0] exp_t [1:5];
    exp_t[1] = {11'd0, 11'd0,     2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_t[2] = {11'd0, 11'h1AB,   2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_t[3] = {11'd1, 11'd0,     2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_t[4] = {11'd1, 11'd0,     2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_t[5] = {11'd1, 11'd0,     2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    fill_mem(16'h0000);
    mem[0] = 16'hF9AB;
    do_reset();
    kick();
    for (int c = 1; c <= 5; c++) begin
      checks++;
      if (obs !== exp_t[c]) begin
        errors++;
        $display("FAIL nop cycle %0d: got %h expected %h", c, obs, exp_t[c]);
      end
      if (c < 5) step();
    end
  endtask

  // All-NOP program: pc must wrap 2047 -> 0 and keep running
  task automatic test_wrap();
    bit found = 1'b0;
    fill_mem(16'h4000);
    do_reset();
    kick();
    for (int n = 0; n < 5000; n++) begin
      if (pc == 11'd2047) begin
        found = 1'b1;
        break;
      end
      step();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL wrap_reach: pc got %0d expected 2047 within budget", pc);
    end
    step();  // EXEC at 2047
    step();  // FETCH after wrap
    checks++;
    if (pc !== 11'd0) begin
      errors++;
      $display("FAIL wrap_zero: got %0d expected 0", pc);
    end
    step();
    step();
    checks++;
    if (pc !== 11'd1 || halted !== 1'b0) begin
      errors++;
      $display("FAIL wrap_continue: got pc=%0d halted=%b expected pc=1 halted=0", pc, halted);
    end
  endtask

  // Reset asserted during the EXEC of STO must suppress the write
  task automatic test_reset_mid_exec();
    fill_mem(16'h0000);
    mem[0] = 16'h0807;  // STO 7
    do_reset();
    kick();
    step();  // EXEC of STO
    checks++;
    if (wr_ram !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre_write: got %b expected 1", wr_ram);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (wr_ram !== 1'b0 || wr_acc !== 1'b0 || rd_ram !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_kill: got wr_ram=%b wr_acc=%b rd_ram=%b expected 0 0 0",
               wr_ram, wr_acc, rd_ram);
    end
    step();
    reset = 1'b0;
    checks++;
    if (obs !== 30'd0) begin
      errors++;
      $display("FAIL mid_after_reset: got %h expected %h", obs, 30'd0);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (wr_ram !== 1'b0 || pc !== 11'd0) begin
        errors++;
        $display("FAIL mid_stays_idle cycle %0d: got wr_ram=%b pc=%0d expected 0 0",
                 c, wr_ram, pc);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    fill_mem(16'h0000);
    test_reset();
    test_ldi_addi_sto();
    test_ld_sub();
    test_nop();
    test_wrap();
    test_reset_mid_exec();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bip_control.md
# bip_control

Instruction sequencer for the accumulator processor. Fetches 16-bit instructions from a synchronous-read program memory, decodes the 5-bit opcode and drives the accumulator datapath control lines (`sel_a`, `sel_b`, `wr_acc`, `op`), the data-memory strobes and the 11-bit operand. It sits between program memory and the datapath. It runs a two-cycle FETCH/EXEC loop from a `start` pulse until a HLT instruction.

## Interface
- `PC_WIDTH`, 11, program-counter / address width
- `INSTR_WIDTH`, 16, instruction width; opcode = `instr[15:11]`, operand = `instr[10:0]`
- `CNT_WIDTH`, 32, cycle-counter width
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  begin execution from IDLE (level sampled, one cycle suffices)
- `instr`  in  16  program memory read data, valid one cycle after `pc`
- `pc`  out  11  program memory address
- `operand`  out  11  `instr[10:0]` during EXEC, 0 otherwise
- `sel_a`  out  2  accumulator source: 00 data memory, 01 immediate, 10 ALU
- `sel_b`  out  1  ALU B operand: 0 data memory, 1 immediate
- `wr_acc`  out  1  accumulator write enable
- `op`  out  1  ALU operation: 0 add, 1 subtract
- `wr_ram`  out  1  data memory write strobe
- `rd_ram`  out  1  data memory read enable
- `halted`  out  1  high in HALT state
- `cycle_count`  out  32  executed-cycle counter (see Configuration)

## Operation
- States: IDLE, FETCH, EXEC, HALT. Reset → IDLE, `pc`=0, `cycle_count`=0.
- IDLE: `start`=1 → FETCH; otherwise stay.
- FETCH: `pc` presented; always → EXEC.
- EXEC: decode `instr`; HLT → HALT (pc unchanged); any other opcode → FETCH with `pc` ← `pc`+1, mod 2^11 (2047 wraps to 0).
- HALT: sticky until `reset`; `start` ignored.
- Decode in EXEC (all other strobes 0):
  - 00000 HLT: none.
  - 00001 STO: `wr_ram`=1.
  - 00010 LD: `rd_ram`=1, `sel_a`=00, `wr_acc`=1.
  - 00011 LDI: `sel_a`=01, `wr_acc`=1.
  - 00100 ADD: `rd_ram`=1, `sel_a`=10, `sel_b`=0, `op`=0, `wr_acc`=1.
  - 00101 ADDI: `sel_a`=10, `sel_b`=1, `op`=0, `wr_acc`=1.
  - 00110 SUB: as ADD with `op`=1.
  - 00111 SUBI: as ADDI with `op`=1.
  - 01000–11111: NOP. No strobes; `pc` increments.
- Outside EXEC: `sel_a`=00, `sel_b`=0, `op`=0, `operand`=0, all strobes 0.

## Timing
- Every instruction takes exactly 2 cycles: FETCH, then EXEC. `start` to first EXEC = 2 cycles.
- Program memory: `instr` for address `pc` is valid in the cycle after FETCH (EXEC).
- Control outputs are combinational from state and `instr`, valid for the whole EXEC cycle. `wr_acc` and `wr_ram` are single-cycle pulses, and the datapath and RAM commit on the EXEC→FETCH edge.
- Data memory read is asynchronous: address `operand`, data consumed in the same EXEC cycle.
- `reset` high forces `wr_acc`, `wr_ram` and `rd_ram` to 0 in that cycle, even mid-EXEC. Next state is IDLE, `pc`=0.
- `halted` is registered: it rises on the edge that leaves the EXEC cycle of the HLT instruction.

## Configuration
- `BIP_CYCLE_COUNTER_EN` defined: `cycle_count` increments by 1 on every clock spent in FETCH or EXEC, holds in IDLE/HALT, and saturates at 2^32−1. Reset clears it.
- Not defined: counter logic is omitted and `cycle_count` is tied to 0.

## Test plan
- Reset/idle: hold `reset` 3 cycles, then idle 5 cycles with `start`=0 → `pc`=0, all strobes 0, `halted`=0, `cycle_count`=0.
- Program LDI 5; ADDI 3; STO 7; HLT, pulse `start`:
  - `wr_acc` pulses in cycles 2 and 4 with `sel_a` 01 then 10, `sel_b`=1.
  - `wr_ram` pulses in cycle 6 with `operand`=7.
  - `halted`=1 after cycle 8; `cycle_count`=8 with macro, 0 without.
- Program LD 3; SUB 4; HLT → during the SUB EXEC: `rd_ram`=1, `op`=1, `sel_b`=0, `operand`=4. `pc` sequence 0,1,2, then holds at 2.
- Opcode 11111 at address 0 followed by HLT → no strobes in the first EXEC, `pc` reaches 1, halts.
- Wrap: program of NOPs with no HLT → `pc` runs 2047 → 0 and execution continues. `start` asserted in HALT has no effect.
- Assert `reset` during the EXEC of STO → `wr_ram`=0 in that cycle; next cycle IDLE, `pc`=0.
